// File: rtl/num_input_ctrl.sv
// num_input_ctrl: producer side of the blocking number-input handshake.
// It debounces the push-button and captures the switch value when a press is
// accepted. It then drives a num_clk rising edge that releases a CPU stalled
// on a read. One press can be held in a pending slot until the CPU reads it.
module num_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic       real_clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic [7:0] sw,
    input  logic       block,
    output logic [7:0] num_in,
    output logic       num_clk,
    output logic       pending,
    output logic       overflow,
    output logic       waiting
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PC_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;

    state_t          state, state_d;
    logic [1:0]      key_sync;
    logic            ks;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic            press_ev;
    logic [PC_W-1:0] pcnt, pcnt_d;
    logic [7:0]      pend_data, pend_data_d, num_in_d;
    logic            num_clk_d, pending_d, overflow_d;
    logic            take_press;

    assign ks = key_sync[1];

    // A press is the cycle in which the debounced level is about to fall.
    // Releases are filtered out because stable must currently be high.
    assign press_ev = stable && (ks != stable) && (db_cnt == DB_LAST);

    assign waiting = block && (state == IDLE) && !pending;

    // Two-flop synchroniser on the raw button. It resets to "released" so
    // that a held key at reset exit looks like one normal debounced press.
    always_ff @(posedge real_clk) begin
        if (reset) key_sync <= 2'b11;
        else       key_sync <= {key_sync[0], key_n};
    end

    // Debounce: accept a new level only after it has been seen unchanged
    // for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge real_clk) begin
        if (reset) begin
            stable <= 1'b1;
            db_cnt <= '0;
        end else if (ks != stable) begin
            if (db_cnt == DB_LAST) begin
                stable <= ks;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Delivery FSM register and the registered outputs it owns.
    always_ff @(posedge real_clk) begin
        if (reset) begin
            state     <= IDLE;
            pcnt      <= '0;
            num_in    <= 8'h00;
            num_clk   <= 1'b0;
            pending   <= 1'b0;
            pend_data <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            pcnt      <= pcnt_d;
            num_in    <= num_in_d;
            num_clk   <= num_clk_d;
            pending   <= pending_d;
            pend_data <= pend_data_d;
            overflow  <= overflow_d;
        end
    end

    // Next-state logic. The pending slot is served before a fresh press.
    // A press that is not delivered directly falls through to the slot
    // capture at the bottom. That capture runs in every state, so num_in
    // never changes while a pulse is in progress.
    always_comb begin
        state_d     = state;
        pcnt_d      = pcnt;
        num_in_d    = num_in;
        num_clk_d   = num_clk;
        pending_d   = pending;
        pend_data_d = pend_data;
        overflow_d  = overflow;
        take_press  = 1'b0;

        case (state)
            IDLE: begin
                if (block && pending) begin
                    num_in_d  = pend_data;
                    pending_d = 1'b0;
                    num_clk_d = 1'b1;
                    pcnt_d    = '0;
                    state_d   = PULSE;
                end else if (block && press_ev) begin
                    num_in_d   = sw;
                    num_clk_d  = 1'b1;
                    pcnt_d     = '0;
                    state_d    = PULSE;
                    take_press = 1'b1;
                end
            end
            PULSE: begin
                if (pcnt == PC_LAST) begin
                    num_clk_d = 1'b0;
                    state_d   = GAP;
                end else begin
                    pcnt_d = pcnt + PC_W'(1);
                end
            end
            // One extra low cycle so back-to-back deliveries stay distinct edges.
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (press_ev && !take_press) begin
            if (!pending_d) begin
                pend_data_d = sw;
                pending_d   = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

endmodule
